// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture
//   Edge-triggered post-trigger capture of a decimated 12-bit ADC stream.
//   After an arm request the block watches decimated samples for a crossing
//   of trig_level in the selected direction. The crossing sample and the
//   POST_DEPTH-1 decimated samples after it are pushed out on data_out.
//
// Parameters
//   POST_DEPTH   decimated samples emitted per trigger (1..65535)
//   AUTO_TIMEOUT ARMED cycles before a forced trigger (AUTO_TRIG_EN only)
//
// Build option
//   AUTO_TRIG_EN  when defined, ARMED forces a trigger after AUTO_TIMEOUT
//                 cycles; when undefined, ARMED waits for a crossing forever.
//
// Ports
//   clk, reset_n      rising-edge clock, async active-low reset
//   adc_data[11:0]    unsigned sample, one per clk
//   decim[7:0]        decimation ratio N (0 -> 1), latched on arm
//   trig_level[11:0]  unsigned threshold
//   trig_edge         0 = rising, 1 = falling
//   arm               single-cycle arm request (IDLE/DONE only)
//   data_out[11:0]    captured sample, zero when data_valid is low
//   data_valid        one pulse per emitted sample
//   busy              ARMED or CAPTURE
//   done              DONE
module adc_trigger_capture #(
  parameter int POST_DEPTH   = 1024,
  parameter int AUTO_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] adc_data,
  input  logic [7:0]  decim,
  input  logic [11:0] trig_level,
  input  logic        trig_edge,
  input  logic        arm,
  output logic [11:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(POST_DEPTH - 1);

  if (POST_DEPTH < 1 || POST_DEPTH > 65535 || AUTO_TIMEOUT < 1) begin : g_bad_param
    $error("adc_trigger_capture: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [11:0] s1_q;
  logic [11:0] prev_q, prev_d;
  logic        pv_q, pv_d;          // prev holds a sample from this arming
  logic [7:0]  dc_q, dc_d;
  logic [7:0]  nm1_q, nm1_d;        // latched N-1
  logic [15:0] idx_q, idx_d;
  logic [11:0] dout_q, dout_d;
  logic        dv_q, dv_d;

  logic strobe, arm_ok, trig, force_trig, emit;

  assign strobe = (dc_q == 8'd0);
  assign arm_ok = arm && (state_q == IDLE || state_q == DONE);
  assign trig   = strobe && pv_q &&
                  (trig_edge ? (prev_q >= trig_level && s1_q <  trig_level)
                             : (prev_q <  trig_level && s1_q >= trig_level));

`ifdef AUTO_TRIG_EN
  localparam int          TW   = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(AUTO_TIMEOUT - 1);
  logic [TW-1:0] tmo_q;

  // tmo_q counts completed ARMED cycles, so the current cycle is the
  // (tmo_q+1)-th; force once that reaches AUTO_TIMEOUT. Saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   tmo_q <= '0;
    else if (arm_ok)                                tmo_q <= '0;
    else if (state_q == ARMED && tmo_q != TLIM)     tmo_q <= tmo_q + 1'b1;
  end

  assign force_trig = (state_q == ARMED) && (tmo_q == TLIM);
`else
  assign force_trig = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dc_d    = (dc_q == nm1_q) ? 8'd0 : dc_q + 8'd1;
    nm1_d   = nm1_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    idx_d   = idx_q;
    dout_d  = 12'd0;
    dv_d    = 1'b0;
    emit    = 1'b0;

    if (strobe) begin
      prev_d = s1_q;
      pv_d   = 1'b1;
    end

    case (state_q)
      ARMED:   emit = strobe && (trig || force_trig);
      CAPTURE: emit = strobe;
      default: emit = 1'b0;
    endcase

    // The trigger sample itself is sample 0, emitted on the same edge.
    if (emit) begin
      dout_d = s1_q;
      dv_d   = 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
        idx_d   = 16'd0;
      end else begin
        state_d = CAPTURE;
        idx_d   = idx_q + 16'd1;
      end
    end

    // Arming restarts decimation phase so the first strobe is the next cycle.
    if (arm_ok) begin
      state_d = ARMED;
      dc_d    = 8'd0;
      nm1_d   = (decim == 8'd0) ? 8'd0 : decim - 8'd1;
      pv_d    = 1'b0;
      idx_d   = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s1_q    <= '0;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      dc_q    <= '0;
      nm1_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= adc_data;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      dc_q    <= dc_d;
      nm1_q   <= nm1_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign busy       = (state_q == ARMED) || (state_q == CAPTURE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_adc_trigger_capture.sv
module tb_adc_trigger_capture;
  localparam int PD   = 1024;
  localparam int SLEN = 12000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] adc_data;
  logic [7:0]  decim;
  logic [11:0] trig_level;
  logic        trig_edge;
  logic        arm;
  logic [11:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        done;

  int vectors = 0;
  int errors  = 0;
  int stim[0:SLEN-1];

  always #5 clk = ~clk;

  adc_trigger_capture #(.POST_DEPTH(PD)) dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .decim(decim),
    .trig_level(trig_level), .trig_edge(trig_edge), .arm(arm),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  // Reference: arm in local cycle 0 (block IDLE/DONE). The k-th decimated
  // sample is the input of cycle k*N. Sample 0 only seeds the comparison;
  // the first j>=1 whose (j-1, j) pair crosses the level is the trigger.
  // Decimated sample j+m appears on data_out in cycle 2+(j+m)*N.
  task automatic run_scn(input string name, input int dec, input int lvl,
                         input bit edg, input int maxlen, input int arm2,
                         input bit scramble);
    int n, jt, c_last, lrun, exd;
    bit exv, exb, exdn;
    n  = (dec == 0) ? 1 : dec;
    jt = -1;
    for (int j = 1; j * n + (PD + 2) * n + 40 < SLEN && j * n < maxlen; j++) begin
      int p, c;
      p = stim[(j - 1) * n];
      c = stim[j * n];
      if (edg ? (p >= lvl && c < lvl) : (p < lvl && c >= lvl)) begin
        jt = j;
        break;
      end
    end
    c_last = (jt < 0) ? -1 : 2 + (jt + PD - 1) * n;
    lrun   = (jt < 0) ? maxlen : c_last + 3 * n + 20;
    decim      = 8'(dec);
    trig_level = 12'(lvl);
    trig_edge  = edg;
    for (int k = 0; k < lrun; k++) begin
      @(posedge clk); #1;
      adc_data = 12'(stim[k]);
      arm      = (k == 0) || (k == arm2);
      if (scramble && k > 0) decim = 8'($urandom_range(0, 255));
      @(negedge clk);
      exv  = (jt >= 0) && (k >= 2 + jt * n) && (k <= c_last) && ((k - 2) % n == 0);
      exd  = exv ? stim[k - 2] : 0;
      exb  = (jt < 0) || (k < c_last);
      exdn = (jt >= 0) && (k >= c_last);
      vectors++;
      if (data_valid !== exv) begin
        errors++;
        $display("FAIL %s valid cyc=%0d got=%0b exp=%0b", name, k, data_valid, exv);
      end
      vectors++;
      if (data_out !== 12'(exd)) begin
        errors++;
        $display("FAIL %s data cyc=%0d got=%0d exp=%0d", name, k, data_out, exd);
      end
      if (k >= 1) begin
        vectors++;
        if (busy !== exb || done !== exdn) begin
          errors++;
          $display("FAIL %s busy/done cyc=%0d got=%0b/%0b exp=%0b/%0b",
                   name, k, busy, done, exb, exdn);
        end
      end
    end
    arm = 1'b0;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (data_out !== 12'd0 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs got dout=%0d v=%0b b=%0b d=%0b exp all 0",
               name, data_out, data_valid, busy, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; adc_data = 12'd0; decim = 8'd1; trig_level = 12'd0;
    trig_edge = 1'b0; arm = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_ramp_rising();
    for (int k = 0; k < SLEN; k++) stim[k] = k & 4095;
    run_scn("ramp_rise", 1, 2048, 1'b0, SLEN, 600, 1'b0);
  endtask

  task automatic test_ramp_falling();
    for (int k = 0; k < SLEN; k++) stim[k] = (2000 - k) & 4095;
    run_scn("ramp_fall", 4, 1000, 1'b1, SLEN, -1, 1'b1);
  endtask

  task automatic test_no_trigger();
    for (int k = 0; k < SLEN; k++) stim[k] = 100;
    run_scn("no_trig", 1, 2048, 1'b0, 4000, 1500, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check_idle("no_trig_reset");
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    int cnt, k;
    bit hit;
    cnt = 0; k = 0; hit = 1'b0;
    decim = 8'd1; trig_level = 12'd2048; trig_edge = 1'b0;
    while (k < 5000 && !hit) begin
      @(posedge clk); #1;
      adc_data = 12'(k & 4095);
      arm      = (k == 0);
      @(negedge clk);
      if (data_valid) cnt++;
      if (cnt == 500) hit = 1'b1;
      k++;
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach got=%0d samples exp=500", cnt);
    end
    @(posedge clk); #2 reset_n = 1'b0;
    #1 check_idle("abort_async");
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      adc_data = 12'((k + i) & 4095);
      @(negedge clk);
      check_idle("abort_after");
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int dec, lvl, base, step, a2;
      bit edg, scr;
      dec  = $urandom_range(0, 6);
      lvl  = $urandom_range(1, 4095);
      edg  = 1'($urandom_range(0, 1));
      base = $urandom_range(0, 4095);
      step = $urandom_range(1, 40);
      a2   = $urandom_range(1, 200);
      scr  = 1'($urandom_range(0, 1));
      for (int k = 0; k < SLEN; k++)
        stim[k] = edg ? ((base - k * step) & 4095) : ((base + k * step) & 4095);
      run_scn("random", dec, lvl, edg, SLEN, a2, scr);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_rising();
    test_ramp_falling();
    test_no_trigger();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adc_trigger_capture.md
ADC_TRIGGER_CAPTURE -- requirements
Module: adc_trigger_capture

Interface
REQ-001 SHALL have parameter POST_DEPTH, default 1024: decimated samples emitted per trigger, range 1..65535.
REQ-002 SHALL have parameter AUTO_TIMEOUT, default 1048576: clk cycles in ARMED before a forced trigger; used only with AUTO_TRIG_EN.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port adc_data, input, 12: unsigned ADC sample, new value every clk.
REQ-006 SHALL have port decim, input, 8: decimation ratio N; 0 is treated as 1.
REQ-007 SHALL have port trig_level, input, 12: unsigned trigger threshold.
REQ-008 SHALL have port trig_edge, input, 1: 0 = rising, 1 = falling.
REQ-009 SHALL have port arm, input, 1: single-cycle arm request.
REQ-010 SHALL have port data_out, output, 12: captured sample to the ping-pong FIFO data input.
REQ-011 SHALL have port data_valid, output, 1: data_out qualifier, one cycle per sample.
REQ-012 SHALL have port busy, output, 1: high in ARMED or CAPTURE.
REQ-013 SHALL have port done, output, 1: high in DONE.

Function
REQ-014 SHALL register adc_data once (s1) every cycle; all later logic uses s1 only.
REQ-015 SHALL run decimation counter dc: counts 0..N-1, wraps to 0; strobe when dc==0; dc cleared on every arm acceptance.
REQ-016 SHALL sample decim at arm acceptance only; changes during ARMED/CAPTURE have no effect.
REQ-017 SHALL keep prev = s1 value at last strobe; prev invalid until the first strobe after arming, so no trigger on that strobe.
REQ-018 SHALL detect rising trigger on a strobe when prev < trig_level and s1 >= trig_level; falling when prev >= trig_level and s1 < trig_level.
REQ-019 SHALL implement states IDLE(00), ARMED(01), CAPTURE(10), DONE(11).
REQ-020 SHALL go IDLE->ARMED and DONE->ARMED on arm; arm in ARMED or CAPTURE is ignored.
REQ-021 SHALL go ARMED->CAPTURE on the strobe with a trigger; that trigger sample is output sample 0.
REQ-022 SHALL in CAPTURE, per strobe, emit s1 on data_out with data_valid=1 the next cycle, counting 16-bit sample index.
REQ-023 SHALL go CAPTURE->DONE when sample POST_DEPTH-1 is emitted; exactly POST_DEPTH valid pulses per capture.
REQ-024 SHALL have latency adc_data to data_out of 2 clk; with N=1 data_valid is continuous during capture.
REQ-025 SHALL drive data_out to 12'd0 when data_valid is 0.
REQ-026 SHALL compare on the same strobe that ends capture, but SHALL NOT re-trigger until rearmed.

Reset
REQ-027 SHALL on reset_n low asynchronously force state IDLE, s1, prev, dc, index to 0, data_out=0, data_valid=0, busy=0, done=0.
REQ-028 SHALL on reset mid-capture abort with no further data_valid pulses; restart requires arm.

Configuration
REQ-029 SHALL, with macro AUTO_TRIG_EN defined, count clk cycles in ARMED and force ARMED->CAPTURE at the next strobe once the count reaches AUTO_TIMEOUT, counter cleared on entering ARMED.
REQ-030 SHALL, with AUTO_TRIG_EN undefined, have no timeout counter; ARMED waits indefinitely for a level crossing.

Verification
REQ-031 SHALL cover: decim=1, level=2048, rising, ramp 0..4095 step 1, arm -> first data_out=2048 two cycles after adc_data=2048, 1024 contiguous valids, then done=1.
REQ-032 SHALL cover: decim=4, falling, level=1000, ramp down from 2000 step 1/clk -> valids every 4th cycle, consecutive data_out differing by 4.
REQ-033 SHALL cover: constant adc_data=100, level=2048, without AUTO_TRIG_EN -> busy stays 1, no data_valid for 2^21 cycles.
REQ-034 SHALL cover: same as REQ-033 with AUTO_TRIG_EN, AUTO_TIMEOUT=64 -> capture starts within 65 cycles of arm, data_out=100.
REQ-035 SHALL cover: reset_n low for 1 cycle at capture sample 500 -> outputs 0 immediately; no valids until next arm and trigger; arm during CAPTURE ignored.
